vec_mul_sequencer: RTL and testbench

Parametrised control sequencer for the vector-multiply datapath. It turns one `start` command into a batch of vector-matrix multiplies. For each of up to `2^TILE_W-1` weight tiles it pops the weight FIFO, runs the systolic array's weight reload, and streams `cfg_num_vec` input vectors out of the Unified Buffer. It then writes every latency-aligned result row into the result SRAM at a running destination address. It replaces the fixed-count enable/counter glue around the multiplier with a proper FSM and adds stall-on-empty, abort, and a start/busy/done handshake.

---
 rtl/vec_mul_sequencer_pkg.sv | 32 +++
 rtl/vec_mul_sequencer_valid_delay_line.sv | 43 ++++
 rtl/vec_mul_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_vec_mul_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mul_sequencer_pkg.sv
// Shared types and sizing helpers for the vector-multiply control sequencer.
// Widths depend on module parameters, so each module derives them through these functions.
package vec_mul_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_RELOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The delay line always has at least one stage.
    function automatic int delay_depth(input int latency);
        return (latency < 1) ? 1 : latency;
    endfunction

    localparam int DEF_ADDRESSSIZE    = 10;
    localparam int DEF_TILE_W         = 4;
    localparam int DEF_PIPE_LATENCY   = 65;
    localparam int DEF_WRELOAD_CYCLES = 64;
    localparam int DEF_DELAY_DEPTH    = delay_depth(DEF_PIPE_LATENCY);
    localparam int DEF_VEC_CNT_W      = DEF_ADDRESSSIZE;
    localparam int DEF_RELOAD_CNT_W   = cnt_width(DEF_WRELOAD_CYCLES);

endpackage

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
// 1-bit valid shift register aligning UB read issue with the datapath's result row.
// Synchronous clear discards every in-flight bit; clear takes priority over shifting.
module valid_delay_line #(
    parameter int DEPTH = 65
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] shift;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift <= '0;
                end else if (clr) begin
                    shift <= '0;
                end else begin
                    shift <= din;
                end
            end
        end else begin : g_multi
            // NOTE: sequential state is written only with non-blocking assignments so every
            // stage samples its neighbour's pre-edge value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift <= '0;
                end else if (clr) begin
                    shift <= '0;
                end else begin
                    shift <= {shift[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = shift[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Batch sequencer: per weight tile pops the FIFO, reloads the array, streams N UB vectors,
// then drains latency-aligned results into the result SRAM at a running address.
module vec_mul_sequencer
    import vec_mul_sequencer_pkg::*;
#(
    parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int TILE_W         = DEF_TILE_W,
    parameter int PIPE_LATENCY   = DEF_PIPE_LATENCY,
    parameter int WRELOAD_CYCLES = DEF_WRELOAD_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_src_base,
    input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
    input  logic [ADDRESSSIZE-1:0] cfg_num_vec,
    input  logic [TILE_W-1:0]      cfg_num_tiles,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   weight_reload,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done
);

    localparam int AW       = ADDRESSSIZE;
    localparam int DL_DEPTH = delay_depth(PIPE_LATENCY);
    localparam int RW       = cnt_width(WRELOAD_CYCLES);

    state_t state, state_nxt;

    logic [AW-1:0]     src_base, num_vec;
    logic [TILE_W-1:0] num_tiles, tile_cnt;
    logic [AW-1:0]     vec_cnt, res_cnt, res_ptr;
    logic [RW-1:0]     reload_cnt;

    logic kill, accept, cfg_zero;
    logic last_reload, last_vec, last_res, last_tile;
    logic dl_out;

    assign kill        = abort && (state != S_IDLE);
    assign accept      = start && !abort && (state == S_IDLE);
    assign cfg_zero    = (cfg_num_vec == '0) || (cfg_num_tiles == '0);
    assign last_reload = (reload_cnt == RW'(WRELOAD_CYCLES - 1));
    assign last_vec    = (vec_cnt == num_vec - AW'(1));
    assign last_res    = res_we && (res_cnt == num_vec - AW'(1));
    assign last_tile   = (tile_cnt == num_tiles - TILE_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output and the next state get a default before the case, so no path
    // through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        fifo_rd_en    = 1'b0;
        weight_reload = 1'b0;
        ub_rd_en      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = cfg_zero ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                busy = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = S_RELOAD;
                end
            end
            S_RELOAD: begin
                busy          = 1'b1;
                weight_reload = 1'b1;
                if (last_reload) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                busy     = 1'b1;
                ub_rd_en = 1'b1;
                if (last_vec) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_res) begin
                    state_nxt = last_tile ? S_DONE : S_LOAD_W;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every strobe in the cycle it is seen.
        if (kill) begin
            state_nxt     = S_IDLE;
            fifo_rd_en    = 1'b0;
            weight_reload = 1'b0;
            ub_rd_en      = 1'b0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_base   <= '0;
            num_vec    <= '0;
            num_tiles  <= '0;
            res_ptr    <= '0;
            vec_cnt    <= '0;
            res_cnt    <= '0;
            tile_cnt   <= '0;
            reload_cnt <= '0;
        end else if (kill) begin
            vec_cnt    <= '0;
            res_cnt    <= '0;
            tile_cnt   <= '0;
            reload_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        src_base   <= cfg_src_base;
                        num_vec    <= cfg_num_vec;
                        num_tiles  <= cfg_num_tiles;
                        res_ptr    <= cfg_dst_base;
                        vec_cnt    <= '0;
                        res_cnt    <= '0;
                        tile_cnt   <= '0;
                        reload_cnt <= '0;
                    end
                end
                S_RELOAD: reload_cnt <= last_reload ? '0 : reload_cnt + RW'(1);
                S_STREAM: vec_cnt    <= last_vec ? '0 : vec_cnt + AW'(1);
                S_DRAIN: begin
                    if (last_res) begin
                        tile_cnt <= tile_cnt + TILE_W'(1);
                    end
                end
                default: ;
            endcase
            // Result pointer runs across tiles; the per-tile count finds the last write.
            if (res_we) begin
                res_ptr <= res_ptr + AW'(1);
                res_cnt <= last_res ? '0 : res_cnt + AW'(1);
            end
        end
    end

    valid_delay_line #(
        .DEPTH(DL_DEPTH)
    ) u_valid_delay_line (
        .clk (clk),
        .rst (rst),
        .clr (kill),
        .din (ub_rd_en),
        .dout(dl_out)
    );

    assign res_we   = dl_out && !kill;
    assign res_addr = res_ptr;
    assign ub_addr  = src_base + vec_cnt;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Scoreboard bench for vec_mul_sequencer: stimulus pushes expected cycle/address events,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_vec_mul_sequencer;

    localparam int AW = 10;
    localparam int TW = 4;
    localparam int L  = 3;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, fifo_empty;
    logic [AW-1:0] cfg_src_base, cfg_dst_base, cfg_num_vec;
    logic [TW-1:0] cfg_num_tiles;
    logic          fifo_rd_en, weight_reload, ub_rd_en, res_we, busy, done;
    logic [AW-1:0] ub_addr, res_addr;

    vec_mul_sequencer #(
        .ADDRESSSIZE   (AW),
        .TILE_W        (TW),
        .PIPE_LATENCY  (L),
        .WRELOAD_CYCLES(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_num_vec  (cfg_num_vec),
        .cfg_num_tiles(cfg_num_tiles),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .weight_reload(weight_reload),
        .ub_rd_en     (ub_rd_en),
        .ub_addr      (ub_addr),
        .res_we       (res_we),
        .res_addr     (res_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } ev_t;

    int  exp_fifo[$];
    ev_t exp_ub[$];
    ev_t exp_res[$];
    int  exp_done[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    int  mon_e;
    ev_t mon_ev;
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) begin
                if (exp_fifo.size() == 0) check("fifo_rd_en unexpected", cyc, -1);
                else begin
                    mon_e = exp_fifo.pop_front();
                    check("fifo_rd_en cycle", cyc, mon_e);
                end
            end
            if (ub_rd_en) begin
                if (exp_ub.size() == 0) check("ub_rd_en unexpected", cyc, -1);
                else begin
                    mon_ev = exp_ub.pop_front();
                    check("ub_rd_en cycle", cyc, mon_ev.cyc);
                    check("ub_addr", int'(ub_addr), int'(mon_ev.addr));
                end
            end
            if (res_we) begin
                if (exp_res.size() == 0) check("res_we unexpected", cyc, -1);
                else begin
                    mon_ev = exp_res.pop_front();
                    check("res_we cycle", cyc, mon_ev.cyc);
                    check("res_addr", int'(res_addr), int'(mon_ev.addr));
                end
            end
            if (done) begin
                check("busy with done", int'(busy), 0);
                if (exp_done.size() == 0) check("done unexpected", cyc, -1);
                else begin
                    mon_e = exp_done.pop_front();
                    check("done cycle", cyc, mon_e);
                end
            end
        end
    end

    // Hand-derived timeline: tile k offset o = k*(1+W+N+L) + stall.
    task automatic push_batch(input int t, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                              input int nvec, input int tiles, input int s);
        int  per;
        int  o;
        ev_t ev;
        if (nvec == 0 || tiles == 0) begin
            exp_done.push_back(t + 1);
            return;
        end
        per = 1 + W + nvec + L;
        for (int k = 0; k < tiles; k++) begin
            o = k * per + s;
            exp_fifo.push_back(t + 1 + o);
            for (int v = 0; v < nvec; v++) begin
                ev.cyc  = t + 2 + W + o + v;
                ev.addr = src + AW'(v);
                exp_ub.push_back(ev);
                ev.cyc  = t + 2 + W + L + o + v;
                ev.addr = dst + AW'(k * nvec + v);
                exp_res.push_back(ev);
            end
        end
        exp_done.push_back(t + tiles * per + 1 + s);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the start cycle T, with cfg scrambled to prove it was captured.
    task automatic issue(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [AW-1:0] nvec, input logic [TW-1:0] tiles,
                         input int s, output int t);
        @(posedge clk);
        #1;
        cfg_src_base  = src;
        cfg_dst_base  = dst;
        cfg_num_vec   = nvec;
        cfg_num_tiles = tiles;
        start         = 1'b1;
        t             = cyc;
        push_batch(t, src, dst, int'(nvec), int'(tiles), s);
        @(posedge clk);
        #1;
        start         = 1'b0;
        cfg_src_base  = 10'h155;
        cfg_dst_base  = 10'h2AA;
        cfg_num_vec   = 10'd7;
        cfg_num_tiles = 4'd3;
    endtask

    task automatic drained(input string name);
        check({name, " leftover events"},
              exp_fifo.size() + exp_ub.size() + exp_res.size() + exp_done.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " fifo_rd_en"}, int'(fifo_rd_en), 0);
        check({tag, " weight_reload"}, int'(weight_reload), 0);
        check({tag, " ub_rd_en"}, int'(ub_rd_en), 0);
        check({tag, " ub_addr"}, int'(ub_addr), 0);
        check({tag, " res_we"}, int'(res_we), 0);
        check({tag, " res_addr"}, int'(res_addr), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
    endtask

    int t;

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        fifo_empty    = 1'b0;
        cfg_src_base  = '0;
        cfg_dst_base  = '0;
        cfg_num_vec   = '0;
        cfg_num_tiles = '0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        // Basic two-tile batch.
        issue(10'h010, 10'h100, 10'd4, 4'd2, 0, t);
        idle(25);
        drained("basic");

        // FIFO empty through T+1..T+5 shifts everything by five.
        fifo_empty = 1'b1;
        issue(10'h010, 10'h100, 10'd4, 4'd2, 5, t);
        repeat (5) @(posedge clk);
        #1 fifo_empty = 1'b0;
        idle(30);
        drained("stall");

        // Zero-size commands finish immediately without going busy.
        issue(10'h010, 10'h100, 10'd0, 4'd2, 0, t);
        check("zero vec busy", int'(busy), 0);
        idle(1);
        check("zero vec busy after", int'(busy), 0);
        idle(3);
        drained("zero vec");
        issue(10'h010, 10'h100, 10'd4, 4'd0, 0, t);
        check("zero tiles busy", int'(busy), 0);
        idle(4);
        drained("zero tiles");

        // Destination pointer wraps modulo 2^AW.
        issue(10'h3F0, 10'h3FE, 10'd4, 4'd1, 0, t);
        idle(15);
        drained("wrap");

        // Abort in DRAIN with two results still in flight.
        issue(10'h030, 10'h040, 10'd4, 4'd1, 0, t);
        void'(exp_res.pop_back());
        void'(exp_res.pop_back());
        void'(exp_done.pop_back());
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort idle next cycle busy", int'(busy), 0);
        idle(10);
        drained("abort");
        issue(10'h030, 10'h040, 10'd4, 4'd1, 0, t);
        idle(15);
        drained("after abort");

        // Start while busy (zero-size cfg would otherwise pulse done) is ignored.
        issue(10'h050, 10'h060, 10'd4, 4'd1, 0, t);
        repeat (3) @(posedge clk);
        #1;
        cfg_num_vec = 10'd0;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        idle(15);
        drained("start while busy");

        // Start and abort together in IDLE: nothing happens.
        @(posedge clk);
        #1;
        cfg_src_base  = 10'h011;
        cfg_dst_base  = 10'h022;
        cfg_num_vec   = 10'd3;
        cfg_num_tiles = 4'd1;
        start         = 1'b1;
        abort         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", int'(busy), 0);
        idle(1);
        check("start+abort busy later", int'(busy), 0);
        idle(15);
        drained("start+abort");

        // Asynchronous reset in the middle of STREAM.
        issue(10'h070, 10'h080, 10'd4, 4'd1, 0, t);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("mid-stream reset");
        exp_fifo.delete();
        exp_ub.delete();
        exp_res.delete();
        exp_done.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        idle(3);
        issue(10'h070, 10'h080, 10'd2, 4'd2, 0, t);
        idle(25);
        drained("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
